// File: rtl/mem_bus_responder_if.sv
// CPU-side bus bundle for the memory responder: request fields driven by the CPU,
// response fields and the window-hit flag driven by the responder.
interface mem_bus_responder_if;
    logic [15:0] addr_in;
    logic        rw;
    logic        bus_req;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        rdy;
    logic        hit;

    modport master (
        output addr_in, rw, bus_req, data_in,
        input  data_out, data_oe, rdy, hit
    );

    modport slave (
        input  addr_in, rw, bus_req, data_in,
        output data_out, data_oe, rdy, hit
    );
endinterface

// File: rtl/mem_bus_responder.sv
// 256-byte memory window on a CPU bus with programmable wait states.
// Requests are latched in IDLE or RESP, stalled in WAIT, and answered for one cycle in RESP.
module mem_bus_responder #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned WAIT_CYC  = 1
) (
    input  logic                phi2,
    input  logic                rst_b,
    mem_bus_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_LOAD = (WAIT_CYC == 0) ? 3'd0 : 3'(WAIT_CYC - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rdy_q, rdy_d;
    logic        data_oe_q, data_oe_d;
    logic [7:0]  data_out_q, data_out_d;

    logic [7:0]  mem [256];
    logic        hit;
    logic        mem_we;
    logic [7:0]  rd_data;

    assign hit = (bus.addr_in[15:8] == BASE_ADDR[15:8]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (bus.bus_req && hit) begin
                    addr_d  = bus.addr_in[7:0];
                    rw_d    = bus.rw;
                    wdata_d = bus.data_in;
                    if (WAIT_CYC > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (state_q == S_RESP) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A write commits at the end of its RESP cycle; a read entering RESP on that
    // same edge must see the new byte, so the write data is forwarded.
    always_comb begin
        mem_we     = (state_q == S_RESP) && !rw_q;
        rd_data    = (mem_we && (addr_q == addr_d)) ? wdata_q : mem[addr_d];
        rdy_d      = (state_d != S_WAIT);
        data_oe_d  = (state_d == S_RESP) && rw_d;
        data_out_d = data_oe_d ? rd_data : data_out_q;
    end

    always_ff @(posedge phi2 or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= 8'h00;
            rw_q       <= 1'b0;
            wdata_q    <= 8'h00;
            rdy_q      <= 1'b1;
            data_oe_q  <= 1'b0;
            data_out_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            rdy_q      <= rdy_d;
            data_oe_q  <= data_oe_d;
            data_out_q <= data_out_d;
        end
    end

    // Contents survive reset; an aborted write never commits because reset forces IDLE.
    always_ff @(posedge phi2) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.hit      = hit;
    assign bus.rdy      = rdy_q;
    assign bus.data_oe  = data_oe_q;
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Four responders with different window bases and wait counts share one CPU stimulus;
// a transaction-timing model predicts rdy/data_oe/data_out/hit for each of them.
module tb_mem_bus_responder;

    logic        phi2    = 1'b0;
    logic        rst_b   = 1'b0;
    logic [15:0] addr    = 16'h0000;
    logic        rw      = 1'b1;
    logic        bus_req = 1'b0;
    logic [7:0]  din     = 8'h00;

    logic       dut_rdy  [4];
    logic       dut_oe   [4];
    logic       dut_hit  [4];
    logic [7:0] dut_dout [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 phi2 = ~phi2;

    function automatic int wc_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [15:0] base_of(input int i);
        return (i == 2) ? 16'h0200 : 16'h0000;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        mem_bus_responder_if bus ();
        assign bus.addr_in  = addr;
        assign bus.rw       = rw;
        assign bus.bus_req  = bus_req;
        assign bus.data_in  = din;
        assign dut_rdy[gi]  = bus.rdy;
        assign dut_oe[gi]   = bus.data_oe;
        assign dut_hit[gi]  = bus.hit;
        assign dut_dout[gi] = bus.data_out;

        mem_bus_responder #(
            .BASE_ADDR (base_of(gi)),
            .WAIT_CYC  (wc_of(gi))
        ) u_dut (
            .phi2  (phi2),
            .rst_b (rst_b),
            .bus   (bus)
        );
    end

    // Reference model: an accepted request at edge e occupies edges e..e+W,
    // responds in the cycle after edge e+W and frees the responder at edge e+W+1.
    logic [7:0] mm [4][256];
    bit         pend   [4] = '{0, 0, 0, 0};
    int         p_edge [4];
    logic [7:0] p_addr [4];
    bit         p_rw   [4];
    logic [7:0] p_data [4];
    bit         exp_rdy  [4] = '{1, 1, 1, 1};
    bit         exp_oe   [4] = '{0, 0, 0, 0};
    logic [7:0] exp_dout [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int         cyc = 0;

    initial begin
        int w;
        logic [15:0] b;
        forever begin
            @(posedge phi2 or negedge rst_b);
            if (!rst_b) begin
                for (int i = 0; i < 4; i++) begin
                    pend[i] = 0; exp_rdy[i] = 1; exp_oe[i] = 0; exp_dout[i] = 8'h00;
                end
            end else begin
                cyc++;
                for (int i = 0; i < 4; i++) begin
                    w = wc_of(i);
                    b = base_of(i);
                    if (pend[i] && cyc == p_edge[i] + w + 1) begin
                        if (!p_rw[i]) mm[i][p_addr[i]] = p_data[i];
                        pend[i] = 0;
                    end
                    if (!pend[i] && bus_req && addr[15:8] == b[15:8]) begin
                        pend[i] = 1; p_edge[i] = cyc; p_addr[i] = addr[7:0];
                        p_rw[i] = rw; p_data[i] = din;
                    end
                    if (pend[i] && cyc == p_edge[i] + w) begin
                        exp_rdy[i] = 1;
                        exp_oe[i]  = p_rw[i];
                        if (p_rw[i]) exp_dout[i] = mm[i][p_addr[i]];
                    end else begin
                        exp_rdy[i] = !pend[i];
                        exp_oe[i]  = 0;
                    end
                end
            end
        end
    end

    task automatic tick(input bit req, input logic [15:0] a, input bit r, input logic [7:0] d);
        @(negedge phi2);
        bus_req = req; addr = a; rw = r; din = d;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 16'h0000, 1'b1, 8'h00);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge phi2);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp += 3;
            if (dut_rdy[i] !== 1'b1) begin n_err++; $display("FAIL reset_rdy[%0d]: got %b want 1", i, dut_rdy[i]); end
            if (dut_oe[i] !== 1'b0) begin n_err++; $display("FAIL reset_oe[%0d]: got %b want 0", i, dut_oe[i]); end
            if (dut_dout[i] !== 8'h00) begin n_err++; $display("FAIL reset_dout[%0d]: got %h want 00", i, dut_dout[i]); end
        end
        // first request is presented together with reset release
        @(negedge phi2);
        rst_b = 1'b1; bus_req = 1'b1; addr = 16'h0030; rw = 1'b0; din = 8'h77;
        $display("reset released, write 0030 <= 77");
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 3;
        if (dut_rdy[0] !== 1'b0) begin n_err++; $display("FAIL first_req_w1_rdy: got %b want 0", dut_rdy[0]); end
        if (dut_rdy[3] !== 1'b0) begin n_err++; $display("FAIL first_req_w2_rdy: got %b want 0", dut_rdy[3]); end
        if (dut_rdy[1] !== 1'b1) begin n_err++; $display("FAIL first_req_w0_rdy: got %b want 1", dut_rdy[1]); end
        idle(4);
    endtask

    task automatic init_mem;
        for (int a = 0; a < 256; a++) begin
            tick(1'b1, {8'h00, 8'(a)}, 1'b0, 8'($urandom));
            idle(3);
            tick(1'b1, {8'h02, 8'(a)}, 1'b0, 8'($urandom));
            idle(3);
        end
        $display("memory windows preloaded");
    endtask

    task automatic test_write_read;
        idle(4);
        $display("W=1: write 0010 <= 5A, read 0010");
        tick(1'b1, 16'h0010, 1'b0, 8'h5A);
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 2;
        if (dut_rdy[0] !== 1'b0) begin n_err++; $display("FAIL wr_wait_rdy: got %b want 0", dut_rdy[0]); end
        if (dut_oe[0] !== 1'b0) begin n_err++; $display("FAIL wr_wait_oe: got %b want 0", dut_oe[0]); end
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 2;
        if (dut_rdy[0] !== 1'b1) begin n_err++; $display("FAIL wr_resp_rdy: got %b want 1", dut_rdy[0]); end
        if (dut_oe[0] !== 1'b0) begin n_err++; $display("FAIL wr_resp_oe: got %b want 0", dut_oe[0]); end
        tick(1'b1, 16'h0010, 1'b1, 8'h00);
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 1;
        if (dut_rdy[0] !== 1'b0) begin n_err++; $display("FAIL rd_wait_rdy: got %b want 0", dut_rdy[0]); end
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 3;
        if (dut_rdy[0] !== 1'b1) begin n_err++; $display("FAIL rd_resp_rdy: got %b want 1", dut_rdy[0]); end
        if (dut_oe[0] !== 1'b1) begin n_err++; $display("FAIL rd_resp_oe: got %b want 1", dut_oe[0]); end
        if (dut_dout[0] !== 8'h5A) begin n_err++; $display("FAIL rd_resp_data: got %h want 5a", dut_dout[0]); end
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 2;
        if (dut_oe[0] !== 1'b0) begin n_err++; $display("FAIL rd_after_oe: got %b want 0", dut_oe[0]); end
        if (dut_dout[0] !== 8'h5A) begin n_err++; $display("FAIL rd_hold_data: got %h want 5a", dut_dout[0]); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] x;
        idle(4);
        $display("W=0: preload 0001 <= 11, 0002 <= 22, back-to-back reads");
        tick(1'b1, 16'h0001, 1'b0, 8'h11); idle(3);
        tick(1'b1, 16'h0002, 1'b0, 8'h22); idle(3);
        tick(1'b1, 16'h0001, 1'b1, 8'h00);
        tick(1'b1, 16'h0002, 1'b1, 8'h00);
        n_cmp += 3;
        if (dut_rdy[1] !== 1'b1) begin n_err++; $display("FAIL b2b_rdy0: got %b want 1", dut_rdy[1]); end
        if (dut_oe[1] !== 1'b1) begin n_err++; $display("FAIL b2b_oe0: got %b want 1", dut_oe[1]); end
        if (dut_dout[1] !== 8'h11) begin n_err++; $display("FAIL b2b_data0: got %h want 11", dut_dout[1]); end
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 3;
        if (dut_rdy[1] !== 1'b1) begin n_err++; $display("FAIL b2b_rdy1: got %b want 1", dut_rdy[1]); end
        if (dut_oe[1] !== 1'b1) begin n_err++; $display("FAIL b2b_oe1: got %b want 1", dut_oe[1]); end
        if (dut_dout[1] !== 8'h22) begin n_err++; $display("FAIL b2b_data1: got %h want 22", dut_dout[1]); end
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 1;
        if (dut_oe[1] !== 1'b0) begin n_err++; $display("FAIL b2b_oe_end: got %b want 0", dut_oe[1]); end
        idle(4);
        x = 8'($urandom);
        $display("W=0: write 0005 <= %h then read 0005 next cycle", x);
        tick(1'b1, 16'h0005, 1'b0, x);
        tick(1'b1, 16'h0005, 1'b1, 8'h00);
        n_cmp += 1;
        if (dut_oe[1] !== 1'b0) begin n_err++; $display("FAIL raw_wr_oe: got %b want 0", dut_oe[1]); end
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 2;
        if (dut_oe[1] !== 1'b1) begin n_err++; $display("FAIL raw_rd_oe: got %b want 1", dut_oe[1]); end
        if (dut_dout[1] !== x) begin n_err++; $display("FAIL raw_rd_data: got %h want %h", dut_dout[1], x); end
    endtask

    task automatic test_wait_ignore;
        logic [7:0] want;
        idle(6);
        want = mm[2][8'h80];
        $display("W=3 base 0200: read 0280 with bus_req pulsed during WAIT");
        tick(1'b1, 16'h0280, 1'b1, 8'h00);
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 1;
        if (dut_rdy[2] !== 1'b0) begin n_err++; $display("FAIL w3_rdy_c1: got %b want 0", dut_rdy[2]); end
        tick(1'b1, 16'h0281, 1'b1, 8'h00);
        n_cmp += 1;
        if (dut_rdy[2] !== 1'b0) begin n_err++; $display("FAIL w3_rdy_c2: got %b want 0", dut_rdy[2]); end
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 1;
        if (dut_rdy[2] !== 1'b0) begin n_err++; $display("FAIL w3_rdy_c3: got %b want 0", dut_rdy[2]); end
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 3;
        if (dut_rdy[2] !== 1'b1) begin n_err++; $display("FAIL w3_resp_rdy: got %b want 1", dut_rdy[2]); end
        if (dut_oe[2] !== 1'b1) begin n_err++; $display("FAIL w3_resp_oe: got %b want 1", dut_oe[2]); end
        if (dut_dout[2] !== want) begin n_err++; $display("FAIL w3_resp_data: got %h want %h", dut_dout[2], want); end
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 16'h0000, 1'b1, 8'h00);
            n_cmp += 2;
            if (dut_rdy[2] !== 1'b1) begin n_err++; $display("FAIL w3_after_rdy: got %b want 1", dut_rdy[2]); end
            if (dut_oe[2] !== 1'b0) begin n_err++; $display("FAIL w3_after_oe: got %b want 0", dut_oe[2]); end
        end
    endtask

    task automatic test_miss;
        logic [7:0] old;
        idle(6);
        old = mm[2][8'hFF];
        $display("base 0200: read 0300, write 01FF <= EE (both miss), read 02FF");
        tick(1'b1, 16'h0300, 1'b1, 8'h00);
        n_cmp += 1;
        if (dut_hit[2] !== 1'b0) begin n_err++; $display("FAIL miss_hit_0300: got %b want 0", dut_hit[2]); end
        tick(1'b1, 16'h01FF, 1'b0, 8'hEE);
        n_cmp += 3;
        if (dut_hit[2] !== 1'b0) begin n_err++; $display("FAIL miss_hit_01ff: got %b want 0", dut_hit[2]); end
        if (dut_rdy[2] !== 1'b1) begin n_err++; $display("FAIL miss_rdy: got %b want 1", dut_rdy[2]); end
        if (dut_oe[2] !== 1'b0) begin n_err++; $display("FAIL miss_oe: got %b want 0", dut_oe[2]); end
        tick(1'b1, 16'h02FF, 1'b1, 8'h00);
        n_cmp += 3;
        if (dut_hit[2] !== 1'b1) begin n_err++; $display("FAIL hit_02ff: got %b want 1", dut_hit[2]); end
        if (dut_rdy[2] !== 1'b1) begin n_err++; $display("FAIL miss_rdy2: got %b want 1", dut_rdy[2]); end
        if (dut_oe[2] !== 1'b0) begin n_err++; $display("FAIL miss_oe2: got %b want 0", dut_oe[2]); end
        idle(4);
        n_cmp += 2;
        if (dut_oe[2] !== 1'b1) begin n_err++; $display("FAIL miss_chk_oe: got %b want 1", dut_oe[2]); end
        if (dut_dout[2] !== old) begin n_err++; $display("FAIL miss_chk_data: got %h want %h", dut_dout[2], old); end
    endtask

    task automatic test_reset_abort;
        logic [7:0] old;
        idle(6);
        old = mm[3][8'h40];
        $display("W=2: write 0040 <= A5 aborted by reset in first WAIT cycle");
        tick(1'b1, 16'h0040, 1'b0, 8'hA5);
        @(negedge phi2);
        rst_b = 1'b0; bus_req = 1'b0;
        #1;
        n_cmp += 3;
        if (dut_rdy[3] !== 1'b1) begin n_err++; $display("FAIL abort_rdy: got %b want 1", dut_rdy[3]); end
        if (dut_oe[3] !== 1'b0) begin n_err++; $display("FAIL abort_oe: got %b want 0", dut_oe[3]); end
        if (dut_dout[3] !== 8'h00) begin n_err++; $display("FAIL abort_dout: got %h want 00", dut_dout[3]); end
        repeat (2) @(negedge phi2);
        rst_b = 1'b1;
        idle(2);
        tick(1'b1, 16'h0040, 1'b1, 8'h00);
        idle(3);
        n_cmp += 2;
        if (dut_oe[3] !== 1'b1) begin n_err++; $display("FAIL abort_rd_oe: got %b want 1", dut_oe[3]); end
        if (dut_dout[3] !== old) begin n_err++; $display("FAIL abort_rd_data: got %h want %h", dut_dout[3], old); end
    endtask

    task automatic test_boundary;
        logic [7:0] ff_val;
        idle(6);
        ff_val = mm[0][8'hFF];
        $display("W=1: write 0000 <= 00, read 00FF and 0000, probe 0100");
        tick(1'b1, 16'h0000, 1'b0, 8'h00);
        n_cmp += 1;
        if (dut_hit[0] !== 1'b1) begin n_err++; $display("FAIL bnd_hit_0000: got %b want 1", dut_hit[0]); end
        idle(3);
        tick(1'b1, 16'h00FF, 1'b1, 8'h00);
        n_cmp += 1;
        if (dut_hit[0] !== 1'b1) begin n_err++; $display("FAIL bnd_hit_00ff: got %b want 1", dut_hit[0]); end
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        tick(1'b1, 16'h0000, 1'b1, 8'h00);
        n_cmp += 2;
        if (dut_oe[0] !== 1'b1) begin n_err++; $display("FAIL bnd_ff_oe: got %b want 1", dut_oe[0]); end
        if (dut_dout[0] !== ff_val) begin n_err++; $display("FAIL bnd_ff_data: got %h want %h", dut_dout[0], ff_val); end
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 1;
        if (dut_rdy[0] !== 1'b0) begin n_err++; $display("FAIL bnd_00_wait: got %b want 0", dut_rdy[0]); end
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 2;
        if (dut_oe[0] !== 1'b1) begin n_err++; $display("FAIL bnd_00_oe: got %b want 1", dut_oe[0]); end
        if (dut_dout[0] !== 8'h00) begin n_err++; $display("FAIL bnd_00_data: got %h want 00", dut_dout[0]); end
        tick(1'b1, 16'h0100, 1'b1, 8'h00);
        n_cmp += 1;
        if (dut_hit[0] !== 1'b0) begin n_err++; $display("FAIL bnd_hit_0100: got %b want 0", dut_hit[0]); end
        tick(1'b0, 16'h0000, 1'b1, 8'h00);
        n_cmp += 2;
        if (dut_rdy[0] !== 1'b1) begin n_err++; $display("FAIL bnd_0100_rdy: got %b want 1", dut_rdy[0]); end
        if (dut_oe[0] !== 1'b0) begin n_err++; $display("FAIL bnd_0100_oe: got %b want 0", dut_oe[0]); end
    endtask

    task automatic test_random;
        bit          req;
        bit          r;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  d;
        idle(6);
        for (int c = 0; c < 300; c++) begin
            req = 1'($urandom_range(1));
            r   = 1'($urandom_range(1));
            a   = {8'($urandom_range(3)), 8'($urandom)};
            d   = 8'($urandom);
            if (req) $display("rand cyc %0d: %s addr %h data %h", c, r ? "read " : "write", a, d);
            tick(req, a, r, d);
            for (int i = 0; i < 4; i++) begin
                b = base_of(i);
                n_cmp += 4;
                if (dut_rdy[i] !== exp_rdy[i]) begin n_err++; $display("FAIL rand_rdy[%0d] cyc %0d: got %b want %b", i, c, dut_rdy[i], exp_rdy[i]); end
                if (dut_oe[i] !== exp_oe[i]) begin n_err++; $display("FAIL rand_oe[%0d] cyc %0d: got %b want %b", i, c, dut_oe[i], exp_oe[i]); end
                if (dut_dout[i] !== exp_dout[i]) begin n_err++; $display("FAIL rand_dout[%0d] cyc %0d: got %h want %h", i, c, dut_dout[i], exp_dout[i]); end
                if (dut_hit[i] !== (a[15:8] == b[15:8])) begin n_err++; $display("FAIL rand_hit[%0d] cyc %0d: got %b want %b", i, c, dut_hit[i], (a[15:8] == b[15:8])); end
            end
        end
    endtask

    initial begin
        test_reset();
        init_mem();
        test_write_read();
        test_back_to_back();
        test_wait_ignore();
        test_miss();
        test_reset_abort();
        test_boundary();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000: base of the 256-byte responder window; the low 8 bits SHALL be zero.
REQ-002 Parameter WAIT_CYC, default 1: wait states inserted per access, legal range 0..7.
REQ-003 phi2  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_b  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to phi2.
REQ-005 addr_in  in  16  CPU address-bus register output.
REQ-006 rw  in  1  1 = read, 0 = write; sampled with bus_req.
REQ-007 bus_req  in  1  one-cycle strobe marking a valid CPU bus cycle.
REQ-008 data_in  in  8  CPU write data, from the data-out register side.
REQ-009 data_out  out  8  read data, registered.
REQ-010 data_oe  out  1  drive enable for the external data bus, registered.
REQ-011 rdy  out  1  CPU ready; 0 stalls the CPU, registered.
REQ-012 hit  out  1  combinational; 1 when addr_in[15:8] == BASE_ADDR[15:8].

Function
REQ-013 Storage SHALL be a 256x8 array indexed by addr[7:0]; array contents SHALL NOT be reset.
REQ-014 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-015 IDLE, with bus_req=1 and hit=1: latch addr_in[7:0], rw and data_in; go to WAIT if WAIT_CYC>0, otherwise go to RESP.
REQ-016 IDLE, with bus_req=1 and hit=0: stay in IDLE; outputs unchanged (miss, no response).
REQ-017 WAIT: a 3-bit counter SHALL load WAIT_CYC-1 on entry and decrement each cycle; at count 0 go to RESP.
REQ-018 rdy SHALL be 0 in every cycle the FSM is in WAIT and 1 in all other states.
REQ-019 bus_req SHALL be ignored in WAIT, without error.
REQ-020 RESP, read: data_out = mem[latched addr] and data_oe = 1 for exactly this one cycle.
REQ-021 RESP, write: mem[latched addr] <= latched data, committed at the end of this cycle; data_oe = 0.
REQ-022 Latency: the request is sampled at edge N; RESP outputs are valid in cycle N+1+WAIT_CYC; rdy is low for cycles N+1..N+WAIT_CYC.
REQ-023 RESP with bus_req=1 and hit=1: accept the request back-to-back, following the REQ-015 transition. Otherwise return to IDLE.
REQ-024 data_oe SHALL be 0 in IDLE and WAIT; data_out SHALL hold its last value when data_oe=0.
REQ-025 Read-after-write to the same address: the read SHALL return the newly written value whenever its RESP follows the write's RESP.
REQ-026 Address wrap: addr 0xFF is the last window byte; BASE_ADDR+0x100 SHALL miss.

Reset
REQ-027 On rst_b=0: state = IDLE, counter = 0, rdy = 1, data_oe = 0, data_out = 8'h00, latched addr/rw/data = 0.
REQ-028 Reset asserted mid-access (WAIT or RESP before its edge) SHALL abort the access; a pending write SHALL NOT commit.
REQ-029 After rst_b deasserts, the first bus_req SHALL be accepted on the first phi2 edge.

Verification
REQ-030 WAIT_CYC=1, BASE=0x0000: write 0x5A to 0x0010, then read 0x0010 -> rdy low for 1 cycle each; read RESP shows data_out=0x5A, data_oe=1 at N+2.
REQ-031 WAIT_CYC=0: back-to-back reads of 0x0001 and 0x0002 (preloaded 0x11, 0x22) on consecutive cycles -> rdy stays 1; data_oe=1 on two consecutive cycles with 0x11 then 0x22.
REQ-032 WAIT_CYC=3: read 0x0080 -> rdy=0 for exactly 3 cycles, RESP at N+4; bus_req pulsed during WAIT -> ignored, only one RESP.
REQ-033 BASE=0x0200: read 0x0300 and write 0x01FF -> hit=0, rdy=1, data_oe=0, and no memory change (verified by reading 0x02FF).
REQ-034 WAIT_CYC=2: write 0xA5 to 0x0040, assert rst_b=0 in the first WAIT cycle -> rdy=1, data_oe=0, data_out=0x00 immediately; a later read of 0x0040 returns the prior value, not 0xA5.
REQ-035 Write 0x00 then read 0x00FF and 0x0000 across the window boundary -> both hit; 0x0100 misses.
